// File: rtl/uart_bridge_pkg.sv
// uart_bridge_pkg: shared state encoding and command/reply bytes for the UART bus bridge
package uart_bridge_pkg;
   typedef enum logic [2:0] {IDLE, GET_ADDR, GET_DATA, WAIT_GRANT, ACCESS, WAIT_RDATA, SEND} state_t;
   localparam logic [7:0] CMD_WRITE  = 8'h57;
   localparam logic [7:0] CMD_READ   = 8'h52;
   localparam logic [7:0] CMD_NEXT_W = 8'h4E;
   localparam logic [7:0] CMD_NEXT_R = 8'h4D;
   localparam logic [7:0] RSP_ACK    = 8'h06;
   localparam logic [7:0] RSP_NAK    = 8'h15;
endpackage

// File: rtl/bridge_shift_reg.sv
// bridge_shift_reg: 32-bit LSB-first byte shifter; bytes enter at the top, leave at the bottom
module bridge_shift_reg (
   input  logic        clk,
   input  logic        rst,
   input  logic        clr,
   input  logic        load,
   input  logic        shift,
   input  logic [7:0]  din,
   input  logic [31:0] load_word,
   output logic [31:0] word,
   output logic [1:0]  cnt
);
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         word <= '0;
         cnt  <= '0;
      end else if (load) begin
         word <= load_word;
         cnt  <= '0;
      end else if (clr) begin
         cnt  <= '0;
      end else if (shift) begin
         word <= {din, word[31:8]};
         cnt  <= cnt + 2'd1;
      end
   end
endmodule

// File: rtl/uart_bus_bridge.sv
// uart_bus_bridge: UART byte frames to single-word bus accesses, arbitrating via bus_hold/bus_grant.
// Define BRIDGE_AUTOINC_EN to enable the 'N'/'M' address auto-increment commands.
module uart_bus_bridge
   import uart_bridge_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 100000,
   parameter int RD_LATENCY     = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rx_valid,
   input  logic [7:0]  rx_byte,
   output logic        tx_valid,
   input  logic        tx_ready,
   output logic [7:0]  tx_byte,
   output logic        bus_hold,
   input  logic        bus_grant,
   output logic        bus_req,
   output logic        bus_we,
   output logic [31:0] bus_addr,
   output logic [31:0] bus_wdata,
   input  logic [31:0] bus_rdata,
   output logic        busy,
   output logic [7:0]  err_count
);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
`ifdef BRIDGE_AUTOINC_EN
   localparam bit AUTOINC = 1'b1;
`else
   localparam bit AUTOINC = 1'b0;
`endif
   state_t state;
   logic [TW-1:0] idle_cnt;
   logic [1:0] lat_cnt, tx_last, rx_cnt, tx_cnt;
   logic [31:0] rx_word, tx_word, tx_load_word;
   logic in_get, timeout, next_cmd, cmd_ok, nak, tx_hs, tx_load, unused_tx;
   assign in_get = state == GET_ADDR || state == GET_DATA;
   assign timeout = in_get && !rx_valid && idle_cnt == TW'(TIMEOUT_CYCLES - 1);
   assign next_cmd = AUTOINC && (rx_byte == CMD_NEXT_W || rx_byte == CMD_NEXT_R);
   assign cmd_ok = rx_byte == CMD_WRITE || rx_byte == CMD_READ || next_cmd;
   assign nak = state == IDLE && rx_valid && !cmd_ok;
   assign tx_hs = state == SEND && tx_ready;
   assign tx_load = nak || (state == ACCESS && bus_we) || (state == WAIT_RDATA && lat_cnt == 2'(RD_LATENCY));
   assign tx_load_word = state == WAIT_RDATA ? bus_rdata : {24'h0, state == IDLE ? RSP_NAK : RSP_ACK};
   assign tx_valid = state == SEND;
   assign tx_byte = tx_word[7:0];
   assign bus_hold = state == WAIT_GRANT || state == ACCESS || state == WAIT_RDATA;
   assign bus_req = state == ACCESS;
   assign bus_wdata = rx_word;
   assign busy = state != IDLE;
   assign unused_tx = ^tx_word[31:8];

   bridge_shift_reg u_rx (
      .clk(clk), .rst(rst), .clr(timeout), .load(1'b0), .shift(in_get && rx_valid),
      .din(rx_byte), .load_word(32'h0), .word(rx_word), .cnt(rx_cnt)
   );
   bridge_shift_reg u_tx (
      .clk(clk), .rst(rst), .clr(1'b0), .load(tx_load), .shift(tx_hs),
      .din(8'h00), .load_word(tx_load_word), .word(tx_word), .cnt(tx_cnt)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         idle_cnt  <= '0;
         lat_cnt   <= '0;
         tx_last   <= '0;
         bus_we    <= 1'b0;
         bus_addr  <= '0;
         err_count <= '0;
      end else begin
         idle_cnt <= (in_get && !rx_valid) ? idle_cnt + TW'(1) : '0;
         lat_cnt  <= (state == WAIT_RDATA) ? lat_cnt + 2'd1 : 2'd1;
         if (tx_load) tx_last <= (state == WAIT_RDATA) ? 2'd3 : 2'd0;
         if ((timeout || nak) && err_count != 8'hFF) err_count <= err_count + 8'd1;
         case (state)
            IDLE: if (rx_valid) begin
               if (!cmd_ok) state <= SEND;
               else if (next_cmd) begin
                  bus_addr <= bus_addr + 32'd4;
                  bus_we   <= rx_byte == CMD_NEXT_W;
                  state    <= rx_byte == CMD_NEXT_W ? GET_DATA : WAIT_GRANT;
               end else begin
                  bus_we <= rx_byte == CMD_WRITE;
                  state  <= GET_ADDR;
               end
            end
            GET_ADDR: if (timeout) state <= IDLE;
               else if (rx_valid && rx_cnt == 2'd3) begin
                  // word address: the two byte-select bits are dropped at capture
                  bus_addr <= {rx_byte, rx_word[31:10], 2'b00};
                  state    <= bus_we ? GET_DATA : WAIT_GRANT;
               end
            GET_DATA: if (timeout) state <= IDLE;
               else if (rx_valid && rx_cnt == 2'd3) state <= WAIT_GRANT;
            WAIT_GRANT: if (bus_grant) state <= ACCESS;
            ACCESS: state <= bus_we ? SEND : WAIT_RDATA;
            WAIT_RDATA: if (lat_cnt == 2'(RD_LATENCY)) state <= SEND;
            SEND: if (tx_hs && tx_cnt == tx_last) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule
